// File: rtl/vmicro16_wb_dma_pkg.sv
// Shared constants for the vmicro16 wishbone DMA initiator: FSM state codes,
// GAP phase codes and default widths.
package vmicro16_wb_dma_pkg;

    localparam int unsigned ADDR_WIDTH_DEF     = 16;
    localparam int unsigned DATA_WIDTH_DEF     = 16;
    localparam int unsigned LEN_WIDTH_DEF      = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_GAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Selects which access follows the GAP cycle
    localparam logic PH_READ  = 1'b0;
    localparam logic PH_WRITE = 1'b1;

endpackage

// File: rtl/vmicro16_wb_dma_if.sv
// Wishbone classic bus between the DMA initiator (master) and a slave.
interface vmicro16_wb_dma_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  wb_stb_o;
    logic                  wb_cyc_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_addr_o;
    logic [DATA_WIDTH-1:0] wb_data_o;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic                  wb_ack_i;

    modport master (
        output wb_stb_o, wb_cyc_o, wb_we_o, wb_addr_o, wb_data_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        input  wb_stb_o, wb_cyc_o, wb_we_o, wb_addr_o, wb_data_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/vmicro16_wb_dma_timeout.sv
// Per-access ack watchdog: reloads on entry to RD/WR and counts down on each
// strobed cycle without ack; expired flags the final permitted cycle.
module vmicro16_wb_dma_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic stb,
    input  logic ack,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT_CYCLES);
        end else if (stb && !ack && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = stb && !ack && (cnt == CW'(1));

endmodule

// File: rtl/vmicro16_wb_dma.sv
// Wishbone classic DMA initiator: copies len words src->dst, one read then one
// write per word. Define VMICRO16_WB_DMA_TIMEOUT_EN to enable the ack watchdog.
module vmicro16_wb_dma
    import vmicro16_wb_dma_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned LEN_WIDTH      = LEN_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    vmicro16_wb_dma_if.master     wb
);
    logic [2:0]            state;
    logic                  phase;
    logic [ADDR_WIDTH-1:0] src_ptr;
    logic [ADDR_WIDTH-1:0] dst_ptr;
    logic [LEN_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] buffer;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  stb_q;
    logic                  cyc_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  expired;

`ifdef VMICRO16_WB_DMA_TIMEOUT_EN
    logic access_load;

    assign access_load = ((state == ST_IDLE) && start_i && (len_i != '0))
                       || (state == ST_GAP);

    vmicro16_wb_dma_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .load   (access_load),
        .stb    (stb_q),
        .ack    (wb.wb_ack_i),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            phase   <= PH_READ;
            src_ptr <= '0;
            dst_ptr <= '0;
            count   <= '0;
            buffer  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        src_ptr <= src_addr_i;
                        dst_ptr <= dst_addr_i;
                        count   <= len_i;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len_i == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_RD;
                            stb_q  <= 1'b1;
                            cyc_q  <= 1'b1;
                            we_q   <= 1'b0;
                            addr_q <= src_addr_i;
                        end
                    end
                end
                ST_RD: begin
                    if (wb.wb_ack_i) begin
                        buffer  <= wb.wb_data_i;
                        src_ptr <= src_ptr + ADDR_WIDTH'(1);
                        stb_q   <= 1'b0;
                        phase   <= PH_WRITE;
                        state   <= ST_GAP;
                    end else if (expired) begin
                        stb_q  <= 1'b0;
                        cyc_q  <= 1'b0;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    stb_q <= 1'b1;
                    if (phase == PH_WRITE) begin
                        we_q   <= 1'b1;
                        addr_q <= dst_ptr;
                        state  <= ST_WR;
                    end else begin
                        we_q   <= 1'b0;
                        addr_q <= src_ptr;
                        state  <= ST_RD;
                    end
                end
                ST_WR: begin
                    if (wb.wb_ack_i) begin
                        dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
                        count   <= count - LEN_WIDTH'(1);
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        // count still holds the pre-decrement value here
                        if (count == LEN_WIDTH'(1)) begin
                            cyc_q  <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            phase <= PH_READ;
                            state <= ST_GAP;
                        end
                    end else if (expired) begin
                        stb_q  <= 1'b0;
                        cyc_q  <= 1'b0;
                        we_q   <= 1'b0;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    stb_q  <= 1'b0;
                    cyc_q  <= 1'b0;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign wb.wb_stb_o  = stb_q;
    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_data_o = buffer;

endmodule

// File: tb/tb_vmicro16_wb_dma.sv
// Directed bench for vmicro16_wb_dma against a 1-cycle-ack memory slave.
module tb_vmicro16_wb_dma;
`ifdef VMICRO16_WB_DMA_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src_a = '0;
    logic [15:0] dst_a = '0;
    logic [7:0]  len = '0;
    logic        busy, done, err;
    logic        slave_en = 1'b1;
    logic        ack_q;

    always #5 clk = ~clk;

    vmicro16_wb_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) wb ();

    vmicro16_wb_dma #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .LEN_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start),
        .src_addr_i(src_a), .dst_addr_i(dst_a), .len_i(len),
        .busy_o(busy), .done_o(done), .err_o(err), .wb(wb)
    );

    logic [15:0] mem [0:65535];
    logic [15:0] rd_log [0:255];
    int          nrd = 0;
    int          nwr = 0;
    int          stb_cycles = 0;
    int          done_pulses = 0;
    int          gap_bad = 0;
    logic        prev_acked = 1'b0;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    assign wb.wb_data_i = wb.wb_stb_o ? mem[wb.wb_addr_o] : 16'hDEAD;
    assign wb.wb_ack_i  = ack_q;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= slave_en && wb.wb_stb_o && !ack_q;
            if (wb.wb_stb_o && ack_q) begin
                if (wb.wb_we_o) begin
                    mem[wb.wb_addr_o] <= wb.wb_data_o;
                    nwr <= nwr + 1;
                end else begin
                    rd_log[nrd[7:0]] <= wb.wb_addr_o;
                    nrd <= nrd + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (prev_acked && wb.wb_stb_o) gap_bad++;
        prev_acked = wb.wb_stb_o && wb.wb_ack_i;
        if (wb.wb_stb_o) stb_cycles++;
        if (done) done_pulses++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts a transfer and returns the cycle done_o was seen (-1 if never);
    // at cycle 'poke' a conflicting start request is driven for one cycle.
    task automatic xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                        input int poke, output int done_cyc, output int busy_cyc);
        @(negedge clk);
        start = 1'b1; src_a = s; dst_a = d; len = l;
        @(posedge clk);
        done_cyc = -1;
        busy_cyc = 0;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k == poke) begin
                start = 1'b1; src_a = 16'h0100; dst_a = 16'h0200; len = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = k;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    int dc, bc, s0, r0, w0, d0;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stb", 32'(wb.wb_stb_o), 0);
        check("rst_cyc", 32'(wb.wb_cyc_o), 0);
        check("rst_we", 32'(wb.wb_we_o), 0);
        check("rst_addr", 32'(wb.wb_addr_o), 0);
        check("rst_data", 32'(wb.wb_data_o), 0);
        @(negedge clk);
        reset = 1'b1;

        // len = 0: no bus activity
        s0 = stb_cycles;
        xfer(16'h0000, 16'h0000, 8'd0, 0, dc, bc);
        check("len0_done_cyc", 32'(dc), 1);
        check("len0_busy_cycles", 32'(bc), 1);
        check("len0_no_stb", 32'(stb_cycles - s0), 0);
        @(negedge clk);
        check("len0_busy_after", 32'(busy), 0);

        // 3 words, 0x10 -> 0x20
        s0 = stb_cycles; r0 = nrd; w0 = nwr;
        xfer(16'h0010, 16'h0020, 8'd3, 0, dc, bc);
        check("len3_done_cyc", 32'(dc), 18);
        check("len3_busy_cycles", 32'(bc), 18);
        check("len3_stb_cycles", 32'(stb_cycles - s0), 12);
        check("len3_reads", 32'(nrd - r0), 3);
        check("len3_writes", 32'(nwr - w0), 3);
        for (int i = 0; i < 3; i++) begin
            check("len3_rd_addr", 32'(rd_log[r0 + i]), 32'h10 + 32'(i));
            check("len3_wr_data", 32'(mem[16'h0020 + 16'(i)]), 32'(pat(16'h0010 + 16'(i))));
        end
        check("len3_err", 32'(err), 0);

        // source pointer wraps
        r0 = nrd;
        xfer(16'hFFFF, 16'h0004, 8'd2, 0, dc, bc);
        check("wrap_done_cyc", 32'(dc), 12);
        check("wrap_rd0", 32'(rd_log[r0]), 32'hFFFF);
        check("wrap_rd1", 32'(rd_log[r0 + 1]), 32'h0000);
        check("wrap_wr4", 32'(mem[16'h0004]), 32'(pat(16'hFFFF)));
        check("wrap_wr5", 32'(mem[16'h0005]), 32'(pat(16'h0000)));

        // start mid-transfer is ignored
        w0 = nwr;
        xfer(16'h0030, 16'h0040, 8'd2, 5, dc, bc);
        check("poke_done_cyc", 32'(dc), 12);
        check("poke_writes", 32'(nwr - w0), 2);
        check("poke_wr40", 32'(mem[16'h0040]), 32'(pat(16'h0030)));
        check("poke_wr41", 32'(mem[16'h0041]), 32'(pat(16'h0031)));
        check("poke_untouched", 32'(mem[16'h0200]), 32'(pat(16'h0200)));

`ifdef VMICRO16_WB_DMA_TIMEOUT_EN
        slave_en = 1'b0;
        s0 = stb_cycles; w0 = nwr;
        xfer(16'h0090, 16'h00A0, 8'd2, 0, dc, bc);
        check("to_done_cyc", 32'(dc), 9);
        check("to_stb_cycles", 32'(stb_cycles - s0), 8);
        check("to_err", 32'(err), 1);
        check("to_no_writes", 32'(nwr - w0), 0);
        slave_en = 1'b1;
        xfer(16'h0000, 16'h0000, 8'd0, 0, dc, bc);
        check("to_err_cleared", 32'(err), 0);
`endif

        // reset during WR of word 2 of 4
        @(negedge clk);
        start = 1'b1; src_a = 16'h0050; dst_a = 16'h0060; len = 8'd4;
        @(posedge clk);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        check("rst_mid_in_wr", {30'd0, wb.wb_stb_o, wb.wb_we_o}, 32'h3);
        d0 = done_pulses;
        #2 reset = 1'b0;
        #1;
        check("rst_mid_stb", 32'(wb.wb_stb_o), 0);
        check("rst_mid_cyc", 32'(wb.wb_cyc_o), 0);
        check("rst_mid_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", 32'(done_pulses - d0), 0);
        check("rst_mid_w1", 32'(mem[16'h0060]), 32'(pat(16'h0050)));
        check("rst_mid_w2_absent", 32'(mem[16'h0061]), 32'(pat(16'h0061)));
        xfer(16'h0070, 16'h0080, 8'd1, 0, dc, bc);
        check("post_rst_done_cyc", 32'(dc), 6);
        check("post_rst_wr", 32'(mem[16'h0080]), 32'(pat(16'h0070)));

        check("gap_violations", 32'(gap_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=stalled exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
